// File: rtl/exu_fu_sequencer_if.sv
// Decode / functional-unit / writeback bundle for the execute-stage issue sequencer.
// slave = sequencer side, master = the surrounding pipeline and units.
interface exu_fu_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            issue_valid;
  logic            issue_ready;
  logic [XLEN-1:0] issue_op1;
  logic [XLEN-1:0] issue_op2;
  logic [1:0]      issue_unit;
  logic [1:0]      issue_mode1;
  logic [2:0]      issue_mode2;
  logic [4:0]      issue_rd;
  logic [2:0]      fu_start;
  logic [XLEN-1:0] fu_op1;
  logic [XLEN-1:0] fu_op2;
  logic [1:0]      fu_mode1;
  logic [2:0]      fu_mode2;
  logic [2:0]      fu_done;
  logic [XLEN-1:0] fu_res_sh;
  logic [XLEN-1:0] fu_res_mul;
  logic [XLEN-1:0] fu_res_div;
  logic            wb_valid;
  logic            wb_ready;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      wb_rd;
  logic            wb_err;
  logic            busy;
  logic [15:0]     ops_retired;

  modport slave (
    input  issue_valid, issue_op1, issue_op2, issue_unit, issue_mode1, issue_mode2, issue_rd,
    input  fu_done, fu_res_sh, fu_res_mul, fu_res_div, wb_ready,
    output issue_ready, fu_start, fu_op1, fu_op2, fu_mode1, fu_mode2,
    output wb_valid, wb_data, wb_rd, wb_err, busy, ops_retired
  );

  modport master (
    output issue_valid, issue_op1, issue_op2, issue_unit, issue_mode1, issue_mode2, issue_rd,
    output fu_done, fu_res_sh, fu_res_mul, fu_res_div, wb_ready,
    input  issue_ready, fu_start, fu_op1, fu_op2, fu_mode1, fu_mode2,
    input  wb_valid, wb_data, wb_rd, wb_err, busy, ops_retired
  );
endinterface

// File: rtl/exu_fu_sequencer.sv
// Execute-stage issue sequencer: launches one op on the shift/mul/div unit, waits for its
// done with a timeout, and hands the captured result to writeback.
module exu_fu_sequencer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned XLEN    = 32
) (
  input logic               clk,
  input logic               rst,
  exu_fu_sequencer_if.slave bus
);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e          state_q;
  logic [1:0]      unit_q;
  logic [TW-1:0]   timer_q;
  logic            issue_ready_q;
  logic [2:0]      fu_start_q;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] op2_q;
  logic [1:0]      mode1_q;
  logic [2:0]      mode2_q;
  logic            wb_valid_q;
  logic [XLEN-1:0] wb_data_q;
  logic [4:0]      wb_rd_q;
  logic            wb_err_q;
  logic [15:0]     ops_q;

  logic            done_sel;
  logic [XLEN-1:0] res_sel;

  // Only the launched unit's done/result is ever looked at.
  always_comb begin
    done_sel = 1'b0;
    res_sel  = '0;
    case (unit_q)
      2'd0: begin done_sel = bus.fu_done[0]; res_sel = bus.fu_res_sh;  end
      2'd1: begin done_sel = bus.fu_done[1]; res_sel = bus.fu_res_mul; end
      2'd2: begin done_sel = bus.fu_done[2]; res_sel = bus.fu_res_div; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      unit_q        <= '0;
      timer_q       <= '0;
      issue_ready_q <= 1'b0;
      fu_start_q    <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      mode1_q       <= '0;
      mode2_q       <= '0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      wb_err_q      <= 1'b0;
      ops_q         <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          issue_ready_q <= 1'b1;
          if (issue_ready_q && bus.issue_valid) begin
            issue_ready_q <= 1'b0;
            op1_q         <= bus.issue_op1;
            op2_q         <= bus.issue_op2;
            mode1_q       <= bus.issue_mode1;
            mode2_q       <= bus.issue_mode2;
            unit_q        <= bus.issue_unit;
            wb_rd_q       <= bus.issue_rd;
            if (bus.issue_unit == 2'd3) begin
              // Reserved unit: answer with an error without touching any unit.
              wb_valid_q <= 1'b1;
              wb_err_q   <= 1'b1;
              wb_data_q  <= '0;
              state_q    <= StResp;
            end else begin
              fu_start_q <= 3'b001 << bus.issue_unit;
              state_q    <= StLaunch;
            end
          end
        end
        StLaunch: begin
          fu_start_q <= '0;
          timer_q    <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          if (done_sel) begin
            wb_valid_q <= 1'b1;
            wb_err_q   <= 1'b0;
            wb_data_q  <= res_sel;
            state_q    <= StResp;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            wb_valid_q <= 1'b1;
            wb_err_q   <= 1'b1;
            wb_data_q  <= '0;
            state_q    <= StResp;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StResp: begin
          if (bus.wb_ready) begin
            wb_valid_q    <= 1'b0;
            ops_q         <= ops_q + 16'd1;
            issue_ready_q <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.issue_ready = issue_ready_q;
  assign bus.fu_start    = fu_start_q;
  assign bus.fu_op1      = op1_q;
  assign bus.fu_op2      = op2_q;
  assign bus.fu_mode1    = mode1_q;
  assign bus.fu_mode2    = mode2_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_err      = wb_err_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.ops_retired = ops_q;
endmodule
